lfsr_parity_gen: RTL
====================

Name: lfsr_parity_gen

Overview:
- Parametrised successor to the fixed 7-bit LFSR-with-parity core: a WIDTH-bit maximal-length LFSR with programmable taps.
- Adds runtime seed load, step enable, even/odd parity select, all-zero lock-up recovery and a period counter with a wrap pulse.
- Sits behind the Tiny Tapeout wrapper. The wrapper maps ui_in and uio_in to the controls and uo_out to the state and parity.

Parameters:
- WIDTH, 8, LFSR state width; legal range 3..16.
- TAPS, 8'hB8, feedback mask; a set bit i means state[i] feeds back.
- SEED, 8'h01, reset and recovery state; must be nonzero.

Ports:
- clk  in  1  system clock; all flops on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  advance the LFSR by one step this cycle.
- load  in  1  load seed_in this cycle; priority over en.
- seed_in  in  WIDTH  load value.
- odd_sel  in  1  0 = even parity, 1 = odd parity.
- state_out  out  WIDTH  current LFSR state (registered).
- parity_out  out  1  parity bit over state_out (combinational from registered state and odd_sel).
- step_cnt  out  WIDTH  steps taken since the last reset or load.
- period_done  out  1  one-cycle pulse when state returns to the start value.
- lockup  out  1  one-cycle pulse when zero recovery fires.

Behaviour:
- Reset (async assert, sync release): state_out=SEED, step_cnt=0, period_done=0, lockup=0, start register=SEED.
- Fibonacci step: fb = ^(state & TAPS); next = {state[WIDTH-2:0], fb}.
- Priority per clock edge: load, then zero recovery, then en, then hold.
- load=1:
  - seed_in nonzero: state<=seed_in, start<=seed_in, step_cnt<=0.
  - seed_in zero: state<=SEED, start<=SEED, and lockup pulses.
  - en is ignored in a load cycle.
- Zero recovery:
  - Applies if state==0 in any non-load cycle (reachable only via a bad TAPS).
  - state<=SEED, step_cnt<=0, lockup=1 for one cycle.
- en=1 with no load and nonzero state:
  - state<=next and step_cnt<=step_cnt+1, wrapping modulo 2^WIDTH.
  - If next==start: period_done=1 next cycle and step_cnt<=0.
- en=0: everything holds; pulses deassert.
- Latency: state_out reflects a step one cycle after en is sampled.
- parity_out = (^state_out) ^ odd_sel.
  - Even mode: state plus parity has even ones-count.
  - Odd mode: state plus parity has odd ones-count.
- For maximal TAPS, period_done fires every 2^WIDTH-1 enabled steps; step_cnt never reaches 2^WIDTH-1 visibly because it clears on the wrap.
- Reset mid-stream: immediate return to reset values regardless of en or load.

Optional Feature:
- Macro LFSR_GALOIS_EN.
- Defined: Galois form; next = state[WIDTH-1] ? ((state<<1) ^ TAPS_G) : (state<<1).
  - TAPS_G is the bit-reversed equivalent of TAPS, computed by a package function.
  - Period, load, recovery and counter semantics are unchanged; the sequence order differs.
- Undefined: Fibonacci form as specified above (default).

Decomposition:
- Package lfsr_pkg holds:
  - function reverse_taps(mask, width);
  - constant DEFAULT_TAPS_8 = 8'hB8;
  - constant DEFAULT_SEED = 1.
- One sub-module, lfsr_step (combinational next-state from state and TAPS, under the macro), reused by the wrapper and the bench model.

Test Plan:
1. Reset then en=1 for 4 cycles, WIDTH=8, TAPS=8'hB8, Fibonacci -> state 01,02,04,08,11; parity_out (even) 1,1,1,1,0.
2. en=1 for 255 cycles from reset -> period_done pulses exactly once, on the cycle state returns to 01; step_cnt reads 0 afterwards; no repeats of state before then.
3. load=1, seed_in=8'hA5, with en=1 in the same cycle -> state=A5 (no step), step_cnt=0. odd_sel=1 -> parity_out=1. odd_sel=0 -> parity_out=0.
4. load with seed_in=0 -> state=01, lockup pulses one cycle. Separately, TAPS=8'h00 build from seed 80 -> state reaches 00, then the next cycle recovers to 01 with a lockup pulse.
5. Assert rst for half a cycle mid-run at state 11 with en=1 -> state_out=01 and step_cnt=0 asynchronously, before the next edge; stepping resumes after release.
6. LFSR_GALOIS_EN build, 255 steps from 01 -> single period_done, all 255 nonzero states visited, matching the lfsr_step reference model.

Source files
------------

// File: rtl/lfsr_parity_gen_pkg.sv
// lfsr_parity_gen_pkg: shared constants and the Fibonacci-to-Galois tap reversal helper.
package lfsr_pkg;
  localparam logic [7:0] DEFAULT_TAPS_8 = 8'hB8;
  localparam int DEFAULT_SEED = 1;
  function automatic logic [15:0] reverse_taps(logic [15:0] mask, int width);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (i < width) r[width-1-i] = mask[i];
    return r;
  endfunction
endpackage

// File: rtl/lfsr_parity_gen_if.sv
// lfsr_parity_gen_if: control and status bundle between the LFSR core and its driver.
interface lfsr_parity_gen_if #(parameter int WIDTH = 8);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic             odd_sel;
  logic [WIDTH-1:0] state_out;
  logic             parity_out;
  logic [WIDTH-1:0] step_cnt;
  logic             period_done;
  logic             lockup;
  modport master(output en, load, seed_in, odd_sel,
                 input state_out, parity_out, step_cnt, period_done, lockup);
  modport slave(input en, load, seed_in, odd_sel,
                output state_out, parity_out, step_cnt, period_done, lockup);
endinterface

// File: rtl/lfsr_parity_gen_step.sv
// lfsr_step: combinational LFSR successor; Galois form when LFSR_GALOIS_EN is defined, else Fibonacci.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS_8)
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);
`ifdef LFSR_GALOIS_EN
  localparam logic [WIDTH-1:0] TAPS_G = WIDTH'(reverse_taps(16'(TAPS), WIDTH));
  assign o_next = i_state[WIDTH-1] ? ((i_state << 1) ^ TAPS_G) : (i_state << 1);
`else
  assign o_next = {i_state[WIDTH-2:0], ^(i_state & TAPS)};
`endif
endmodule

// File: rtl/lfsr_parity_gen.sv
// lfsr_parity_gen: programmable-tap LFSR with seed load, parity, zero recovery and period counter.
// Build option LFSR_GALOIS_EN selects the Galois step form inside lfsr_step.
module lfsr_parity_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS_8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input logic              clk,
  input logic              rst,
  lfsr_parity_gen_if.slave bus
);
  logic [WIDTH-1:0] r_state, r_start, r_cnt;
  logic             r_period, r_lockup;
  logic [WIDTH-1:0] w_next;
  logic             w_seed_ok, w_wrap;
  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (.i_state(r_state), .o_next(w_next));
  assign w_seed_ok = |bus.seed_in;
  assign w_wrap    = w_next == r_start;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= SEED;
      r_start  <= SEED;
      r_cnt    <= '0;
      r_period <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_period <= 1'b0;
      r_lockup <= 1'b0;
      if (bus.load) begin
        r_state  <= w_seed_ok ? bus.seed_in : SEED;
        r_start  <= w_seed_ok ? bus.seed_in : SEED;
        r_cnt    <= '0;
        r_lockup <= ~w_seed_ok;
      end else if (r_state == '0) begin
        r_state  <= SEED;
        r_cnt    <= '0;
        r_lockup <= 1'b1;
      end else if (bus.en) begin
        r_state  <= w_next;
        r_cnt    <= w_wrap ? '0 : r_cnt + WIDTH'(1);
        r_period <= w_wrap;
      end
    end
  assign bus.state_out   = r_state;
  assign bus.parity_out  = (^r_state) ^ bus.odd_sel;
  assign bus.step_cnt    = r_cnt;
  assign bus.period_done = r_period;
  assign bus.lockup      = r_lockup;
endmodule
